// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with inter-digit blanking and per-frame input snapshot
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_tick
);
  localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = ACTIVE_LOW;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic {BLANK, DISPLAY} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] sh_val, sh_val_nxt;
  logic [NUM_DIGITS-1:0] sh_dp, sh_dp_nxt, sh_blank, sh_blank_nxt, an_nxt;
  logic [6:0] seg_nxt;
  logic dp_nxt, done, snap, lit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      an_out     <= {NUM_DIGITS{POL}};
      seg_out    <= {7{POL}};
      dp_out     <= POL;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sh_val     <= sh_val_nxt;
      sh_dp      <= sh_dp_nxt;
      sh_blank   <= sh_blank_nxt;
      an_out     <= an_nxt;
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      frame_tick <= snap;
    end
  end
  always_comb begin
    done = state == BLANK ? cnt == CW'(BLANK_CYCLES - 1) : cnt == CW'(DIGIT_CYCLES - 1);
    state_nxt = done ? (state == BLANK ? DISPLAY : BLANK) : state;
    cnt_nxt = done ? '0 : cnt + 1'b1;
    idx_nxt = (done && state == DISPLAY) ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
    snap = done && state == BLANK && idx == '0;
    sh_val_nxt = snap ? value_in : sh_val;
    sh_dp_nxt = snap ? dp_in : sh_dp;
    sh_blank_nxt = snap ? blank_in : sh_blank;
  end
  // Outputs are decoded from next-cycle state so the registered pins line up with the FSM.
  always_comb begin
    lit = state_nxt == DISPLAY;
    an_nxt = {NUM_DIGITS{POL}} ^ ((lit && !sh_blank_nxt[idx]) ? NUM_DIGITS'(1) << idx : '0);
    seg_nxt = {7{POL}} ^ (lit ? HEX[sh_val_nxt[idx*4 +: 4]] : 7'h00);
    dp_nxt = POL ^ (lit & sh_dp_nxt[idx]);
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives a time-multiplexed common-anode 7-segment display from a packed hex value supplied by game logic (score, combo, timer).
- Output-side board I/O counterpart to the button input conditioning: converts stable internal values into timed physical pin activity.
- Cycles one digit at a time, inserts a blanking gap between digits to prevent ghosting, and snapshots the input once per frame so digits never tear.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥1).
- DIGIT_CYCLES, 50000, clk cycles each digit is lit (≥1).
- BLANK_CYCLES, 1000, clk cycles all anodes are off between digits (≥1).
- ACTIVE_LOW, 1, 1 = anode/segment/dp outputs are active-low, 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- value_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit.
- blank_in  input  NUM_DIGITS  1 = digit i stays dark for the frame.
- an_out  output  NUM_DIGITS  digit enables, one-hot active during DISPLAY.
- seg_out  output  7  segments {g,f,e,d,c,b,a}.
- dp_out  output  1  decimal point segment.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- All outputs are registered. "Off" means the inactive level: 1 if ACTIVE_LOW, else 0.
- Reset (rst low, asynchronous):
  - Outputs: an_out, seg_out and dp_out all off; frame_tick = 0.
  - Internal state: state = BLANK, digit index = 0, cycle counter = 0, shadow registers = 0.
  - Reset asserted mid-frame forces outputs off immediately, without waiting for a clock edge.
- FSM states: BLANK and DISPLAY. The counter runs 0..N-1 within each state and clears on every state change.
- BLANK:
  - All anodes, segments and dp are off.
  - When counter == BLANK_CYCLES-1: go to DISPLAY on the next edge.
  - If index == 0 on that edge, capture value_in, dp_in and blank_in into the shadow registers (the frame snapshot).
- DISPLAY:
  - Output timing: outputs take their DISPLAY values on the same edge the state enters DISPLAY, i.e. in its first cycle.
  - an_out = one-hot at the current index, unless shadow blank[index] = 1, in which case all anodes are off.
  - seg_out = hex decode of shadow nibble[index]; dp_out = shadow dp[index].
  - When counter == DIGIT_CYCLES-1: index advances (NUM_DIGITS-1 wraps to 0) and the state goes to BLANK; outputs go off on that edge.
- Hex decode, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - If ACTIVE_LOW = 1, seg_out, an_out and dp_out are bitwise inverted.
- frame_tick: high for exactly the first DISPLAY cycle of digit 0; low otherwise.
- Timing:
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
  - The first DISPLAY begins BLANK_CYCLES cycles after reset release.
- Changes to value_in, dp_in or blank_in mid-frame have no visible effect until the next snapshot.
- There is never a cycle in which two anodes are active, or in which an anode is active while its segments come from another digit.
- NUM_DIGITS = 1: the single digit alternates DISPLAY and BLANK, with a snapshot on every BLANK→DISPLAY transition.

Test Plan (NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1 unless noted):
- Reset, then release with value_in=16'h1234:
  - During reset: an_out=4'b1111, seg_out=7'h7F, dp_out=1, frame_tick=0.
  - 2 cycles after release: an_out=4'b1110, seg_out=7'h19 ('4'), frame_tick=1 for 1 cycle.
  - Digit 3 later shows an_out=4'b0111, seg_out=7'h79 ('1').
- Free run for 200 cycles:
  - frame_tick pulses exactly every 40 cycles.
  - Each anode is low for exactly 8 consecutive cycles.
  - Every anode change is separated by 2 cycles of an_out=4'b1111.
  - Never more than one anode low.
- value_in changes from 16'h1234 to 16'hABCD while digit 2 is lit:
  - Digits 2 and 3 still show '2' and '1'.
  - From the next frame_tick: digit 0 = 7'h21 ('d'), digit 3 = 7'h08 ('A').
- blank_in=4'b0100, dp_in=4'b0001:
  - an_out stays 4'b1111 through digit 2's 8-cycle slot.
  - dp_out=0 only while digit 0 is lit.
- Asynchronous reset asserted mid-DISPLAY (between clock edges):
  - Outputs go off immediately.
  - After release, the sequence restarts at digit 0 after 2 BLANK cycles.
- ACTIVE_LOW=0, value_in nibble 0 = 4'h8: seg_out=7'h7F and an_out=4'b0001 during digit 0.
